// File: rtl/sha_pkg.sv
// Shared definitions for the SHA-2 message schedule: FSM states, small-sigma
// rotate/shift amounts for SHA-256 and SHA-512, and the legal round counts.
package sha_pkg;

  typedef enum logic {
    StLoad   = 1'b0,
    StExpand = 1'b1
  } sha_state_e;

  localparam int unsigned Sha256Rounds = 64;
  localparam int unsigned Sha512Rounds = 80;

  localparam int unsigned S0Rot1W32 = 7;
  localparam int unsigned S0Rot2W32 = 18;
  localparam int unsigned S0ShrW32  = 3;
  localparam int unsigned S1Rot1W32 = 17;
  localparam int unsigned S1Rot2W32 = 19;
  localparam int unsigned S1ShrW32  = 10;

  localparam int unsigned S0Rot1W64 = 1;
  localparam int unsigned S0Rot2W64 = 8;
  localparam int unsigned S0ShrW64  = 7;
  localparam int unsigned S1Rot1W64 = 19;
  localparam int unsigned S1Rot2W64 = 61;
  localparam int unsigned S1ShrW64  = 6;

  // SHA-256 pairs 32-bit words with 64 rounds, SHA-512 pairs 64-bit words with 80.
  function automatic bit sha_cfg_legal(input int unsigned width, input int unsigned rounds);
    return ((width == 32) && (rounds == Sha256Rounds)) ||
           ((width == 64) && (rounds == Sha512Rounds));
  endfunction

endpackage

// File: rtl/sha_small_sigma.sv
// Combinational SHA-2 small sigma function; SEL = 0 gives sigma0, SEL = 1 gives sigma1.
module sha_small_sigma
  import sha_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter bit          SEL   = 1'b0
) (
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);

  localparam int unsigned Rot1 = (WIDTH == 64) ? (SEL ? S1Rot1W64 : S0Rot1W64)
                                               : (SEL ? S1Rot1W32 : S0Rot1W32);
  localparam int unsigned Rot2 = (WIDTH == 64) ? (SEL ? S1Rot2W64 : S0Rot2W64)
                                               : (SEL ? S1Rot2W32 : S0Rot2W32);
  localparam int unsigned Shr  = (WIDTH == 64) ? (SEL ? S1ShrW64 : S0ShrW64)
                                               : (SEL ? S1ShrW32 : S0ShrW32);

  function automatic logic [WIDTH-1:0] rotr(input logic [WIDTH-1:0] x, input int unsigned n);
    return (x >> n) | (x << (WIDTH - n));
  endfunction

  always_comb begin
    data_o = rotr(data_i, Rot1) ^ rotr(data_i, Rot2) ^ (data_i >> Shr);
  end

endmodule

// File: rtl/sha_msg_schedule.sv
// SHA-2 message schedule: loads a 16-word block, then streams W[0..ROUNDS-1]
// from a 16-entry sliding window that is extended by one word per handshake.
module sha_msg_schedule
  import sha_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned ROUNDS = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [6:0]       out_index,
  output logic             out_last
);

  if (!sha_cfg_legal(WIDTH, ROUNDS)) begin : gen_cfg_check
    $error("sha_msg_schedule: illegal WIDTH/ROUNDS combination");
  end

  localparam logic [6:0] LastIdx = 7'(ROUNDS - 1);

  sha_state_e       state_q, state_d;
  logic [3:0]       load_cnt_q, load_cnt_d;
  logic [6:0]       t_q, t_d;
  logic [WIDTH-1:0] w_q [16];
  logic [WIDTH-1:0] w_d [16];
  logic [WIDTH-1:0] sigma0_w, sigma1_w, w_new;
  logic             in_accept, out_accept;

  sha_small_sigma #(
    .WIDTH (WIDTH),
    .SEL   (1'b0)
  ) u_sigma0 (
    .data_i (w_q[1]),
    .data_o (sigma0_w)
  );

  sha_small_sigma #(
    .WIDTH (WIDTH),
    .SEL   (1'b1)
  ) u_sigma1 (
    .data_i (w_q[14]),
    .data_o (sigma1_w)
  );

  always_comb begin
    in_ready   = (state_q == StLoad);
    out_valid  = (state_q == StExpand);
    out_data   = w_q[0];
    out_index  = t_q;
    out_last   = out_valid && (t_q == LastIdx);
    in_accept  = in_valid && in_ready;
    out_accept = out_valid && out_ready;
    w_new      = sigma1_w + w_q[9] + sigma0_w + w_q[0];
  end

  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    t_d        = t_q;
    w_d        = w_q;
    case (state_q)
      StLoad: begin
        if (in_accept) begin
          w_d[load_cnt_q] = in_data;
          if (load_cnt_q == 4'd15) begin
            state_d    = StExpand;
            load_cnt_d = 4'd0;
            t_d        = 7'd0;
          end else begin
            load_cnt_d = load_cnt_q + 4'd1;
          end
        end
      end
      StExpand: begin
        if (out_accept) begin
          for (int i = 0; i < 15; i++) begin
            w_d[i] = w_q[i+1];
          end
          w_d[15] = w_new;
          if (out_last) begin
            state_d    = StLoad;
            load_cnt_d = 4'd0;
            t_d        = 7'd0;
          end else begin
            t_d = t_q + 7'd1;
          end
        end
      end
      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StLoad;
      load_cnt_q <= 4'd0;
      t_q        <= 7'd0;
      for (int i = 0; i < 16; i++) begin
        w_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      t_q        <= t_d;
      w_q        <= w_d;
    end
  end

endmodule

// File: doc/sha_msg_schedule.md
SHA_MSG_SCHEDULE -- requirements
Module: sha_msg_schedule

Interface
REQ-001 SHALL have parameter WIDTH, default 32, word width; legal values 32 (SHA-256) and 64 (SHA-512).
REQ-002 SHALL have parameter ROUNDS, default 64, number of schedule words emitted per block; legal values 64 and 80.
REQ-003 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-004 SHALL have port rst, input, 1, reset; asynchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1, message word offered.
REQ-006 SHALL have port in_ready, output, 1, block accepts a message word.
REQ-007 SHALL have port in_data, input, WIDTH, message word, big-endian order W[0] first.
REQ-008 SHALL have port out_valid, output, 1, schedule word available.
REQ-009 SHALL have port out_ready, input, 1, consumer accepts word.
REQ-010 SHALL have port out_data, output, WIDTH, schedule word W[t].
REQ-011 SHALL have port out_index, output, 7, current t.
REQ-012 SHALL have port out_last, output, 1, high when t == ROUNDS-1 with out_valid.

Function
REQ-013 SHALL implement two states, LOAD and EXPAND; in_ready = (state == LOAD); out_valid = (state == EXPAND).
REQ-014 SHALL, in LOAD, write each accepted word (in_valid & in_ready) into window slot w[load_cnt] and increment load_cnt 0..15.
REQ-015 SHALL enter EXPAND on the edge accepting the 16th word; out_valid SHALL rise the following cycle with out_data = W[0], out_index = 0.
REQ-016 SHALL drive out_data = w[0] at all times in EXPAND (registered, no combinational path from in_data).
REQ-017 SHALL, on each output handshake (out_valid & out_ready), shift w[i] <= w[i+1] for i = 0..14 and load w[15] <= sigma1(w[14]) + w[9] + sigma0(w[1]) + w[0], the sum truncated mod 2^WIDTH.
REQ-018 SHALL use sigma0 = rotr7 ^ rotr18 ^ shr3 and sigma1 = rotr17 ^ rotr19 ^ shr10 for WIDTH 32.
REQ-019 SHALL use sigma0 = rotr1 ^ rotr8 ^ shr7 and sigma1 = rotr19 ^ rotr61 ^ shr6 for WIDTH 64.
REQ-020 SHALL sustain one output word per cycle while out_ready is held high.
REQ-021 SHALL hold out_data, out_index and out_last stable while out_valid & !out_ready.
REQ-022 SHALL, on the handshake with out_last high, return to LOAD with load_cnt = 0; in_ready is high the next cycle.
REQ-023 SHALL ignore in_valid/in_data while in EXPAND.
REQ-024 SHALL not stall LOAD on in_valid gaps; load_cnt holds until the next accepted word.

Reset
REQ-025 SHALL, on rst asserted at any time including mid-LOAD or mid-EXPAND, immediately force state = LOAD, load_cnt = 0, t = 0, in_ready = 1, out_valid = 0, out_last = 0, out_index = 0, out_data = 0, all window registers = 0.
REQ-026 SHALL require a complete new 16-word block after reset; partial words loaded before reset are discarded.

Structure
REQ-027 SHALL place the state enum, the rotation/shift constants for both widths and the legal ROUNDS values in shared package sha_pkg.
REQ-028 SHALL instantiate sub-module sha_small_sigma (parameters WIDTH and SEL selecting sigma0/sigma1, purely combinational) twice.
REQ-029 SHALL flag illegal WIDTH/ROUNDS combinations with an elaboration-time assertion.

Verification
REQ-030 WIDTH 32, "abc" block (W0 = 0x61626380, W1..W14 = 0, W15 = 0x00000018), out_ready = 1 -> W16 = 0x61626380, W17 = 0x000F0000, 64 consecutive valid cycles, out_last on index 63.
REQ-031 WIDTH 64, ROUNDS 80, "abc" block (W0 = 0x6162638000000000, W15 = 0x18) -> W17 = 0x00030000000000C0, out_last on index 79.
REQ-032 WIDTH 32, all 16 words 0xFFFFFFFF -> W16 = 0x203FFFFC (modular wrap checked).
REQ-033 Drop out_ready for 3 cycles at t = 20 -> out_data and out_index = 20 stay stable, W21 follows with no loss or duplication.
REQ-034 Assert rst at t = 30 -> next cycle out_valid = 0, in_ready = 1; a fresh "abc" block then reproduces REQ-030 exactly.
REQ-035 Two blocks back-to-back with in_valid held high -> in_ready asserted the cycle after the last handshake of block 1, and block 2 output matches its reference model.
